// File: rtl/hazard_control_param.sv
// Pipeline hazard unit: drives stage-register write enables and flushes for load-use /
// RAW stalls, taken-branch flushes and data-memory waits, plus saturating perf counters.
module hazard_control_param #(
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int FORWARDING     = 1,
  parameter int BR_FLUSH_DEPTH = 2,
  parameter int COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [REG_AW-1:0]  ex_rd,
  input  logic               ex_we,
  input  logic               ex_is_load,
  input  logic [REG_AW-1:0]  mem_rd,
  input  logic               mem_we,
  input  logic               br_taken,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  input  logic               cnt_clr,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               idex_write,
  output logic               exmem_write,
  output logic               memwb_write,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [COUNT_W-1:0] stall_cycles,
  output logic [COUNT_W-1:0] flush_count
);

  typedef enum logic {IDLE, LSTALL} state_t;

  state_t     state;
  logic [2:0] rem;
  logic       ex_hit, mem_hit, data_hz, stall, mem_wait;

  always_comb begin
    ex_hit   = ex_we & (ex_rd != '0) &
               ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    mem_hit  = mem_we & (mem_rd != '0) &
               ((id_use_rs1 & (mem_rd == id_rs1)) | (id_use_rs2 & (mem_rd == id_rs2)));
    data_hz  = (FORWARDING != 0) ? (ex_hit & ex_is_load) : (ex_hit | mem_hit);
    // LSTALL keeps stalling even though the hazard source has moved past EX
    stall    = data_hz | (state == LSTALL);
    mem_wait = dmem_req & ~dmem_ready;
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    memwb_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (rst && !mem_wait) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = (BR_FLUSH_DEPTH == 2);
      end else if (stall) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rem          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!mem_wait) begin
        if (br_taken) begin
          state <= IDLE;
          rem   <= '0;
        end else if (state == LSTALL) begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) state <= IDLE;
        end else if ((FORWARDING != 0) && data_hz && (LOAD_USE_STALL > 1)) begin
          state <= LSTALL;
          rem   <= 3'(LOAD_USE_STALL - 1);
        end
      end

      if (cnt_clr) begin
        stall_cycles <= '0;
        flush_count  <= '0;
      end else if (!mem_wait) begin
        if (br_taken && (flush_count != '1))
          flush_count <= flush_count + 1'b1;
        if (!br_taken && stall && (stall_cycles != '1))
          stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule
